// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operation encoding and EX <-> multiply/divide unit interface
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_MUL  = 3'd1,
    OP_MADD = 3'd2,
    OP_DIV  = 3'd3,
    OP_MTHI = 3'd4,
    OP_MTLO = 3'd5
  } muldiv_op_t;
endpackage

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_pkg::*;

  logic             req_valid;
  muldiv_op_t       req_op;
  logic             req_unsigned;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output req_valid, req_op, req_unsigned, req_a, req_b, kill,
    input  busy, done, hi, lo
  );

  modport slave (
    input  req_valid, req_op, req_unsigned, req_a, req_b, kill,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply / multiply-add / divide unit owning HI/LO
// One bit per cycle on magnitudes; signs and the MADD accumulate are applied in FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIXUP} state_t;

  state_t             state, state_next;
  muldiv_op_t         op_q;
  logic               uns_q, neg_prod, neg_rem, div_zero;
  logic [WIDTH-1:0]   a_raw, b_raw, mag_b;
  logic [2*WIDTH-1:0] prod, acc;
  logic [CW-1:0]      cnt;

  logic               accept, start, neg_a, neg_b, rem_ge;
  logic [WIDTH-1:0]   mag_a, rem_diff, quo_fix, rem_fix;
  logic [WIDTH:0]     add_sum, rem_shift;
  logic [2*WIDTH-1:0] prod_fix, mul_result;

  assign accept = bus.req_valid & ~bus.busy & ~bus.kill;
  assign start  = accept & (bus.req_op inside {OP_MUL, OP_MADD, OP_DIV});

  assign neg_a = ~uns_q & a_raw[WIDTH-1];
  assign neg_b = ~uns_q & b_raw[WIDTH-1];
  assign mag_a = neg_a ? -a_raw : a_raw;

  // prod holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  assign add_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag_b} : '0);
  assign rem_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, mag_b};
  assign rem_diff  = rem_shift[WIDTH-1:0] - mag_b;

  assign prod_fix   = neg_prod ? -prod : prod;
  assign mul_result = (op_q == OP_MADD) ? prod_fix + acc : prod_fix;
  assign quo_fix    = neg_prod ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
  assign rem_fix    = neg_rem ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = ITER;
      ITER:    if (cnt == CW'(WIDTH - 1)) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (bus.kill) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_NOP;
      uns_q    <= 1'b0;
      neg_prod <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      b_raw    <= '0;
      mag_b    <= '0;
      prod     <= '0;
      acc      <= '0;
      cnt      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.busy <= (state_next != IDLE);
      case (state)
        IDLE: if (accept) begin
          op_q  <= bus.req_op;
          uns_q <= bus.req_unsigned;
          a_raw <= bus.req_a;
          b_raw <= bus.req_b;
          if (bus.req_op == OP_MTHI) bus.hi <= bus.req_a;
          if (bus.req_op == OP_MTLO) bus.lo <= bus.req_a;
        end
        PREP: begin
          neg_prod <= neg_a ^ neg_b;
          neg_rem  <= neg_a;
          div_zero <= (b_raw == '0);
          mag_b    <= neg_b ? -b_raw : b_raw;
          prod     <= {{WIDTH{1'b0}}, mag_a};
          acc      <= {bus.hi, bus.lo};
          cnt      <= '0;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op_q == OP_DIV)
            prod <= {(rem_ge ? rem_diff : rem_shift[WIDTH-1:0]), prod[WIDTH-2:0], rem_ge};
          else
            prod <= {add_sum, prod[WIDTH-1:1]};
        end
        FIXUP: if (!bus.kill) begin
          bus.done <= 1'b1;
          if (op_q == OP_DIV) begin
            bus.hi <= div_zero ? a_raw : rem_fix;
            bus.lo <= div_zero ? '1 : quo_fix;
          end else begin
            {bus.hi, bus.lo} <= mul_result;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed vector table plus kill/reset/busy sequences for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  muldiv_unit_if bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    muldiv_op_t  op;
    logic        uns;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called at a negedge; returns at the negedge of the done cycle (k counts cycles after accept)
  task automatic run_op(input muldiv_op_t op, input logic uns, input logic [31:0] a,
                        input logic [31:0] b, output int done_cycle, output bit busy_ok);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_unsigned = uns;
    bus.req_a = a; bus.req_b = b;
    @(negedge clock);
    bus.req_valid = 1'b0; bus.req_a = ~a; bus.req_b = ~b ^ 32'h5a5a_a5a5;
    done_cycle = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      if (bus.done) begin
        done_cycle = k;
        if (bus.busy) busy_ok = 1'b0;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic move_op(input muldiv_op_t op, input logic [31:0] a);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a;
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic step(input int n, inout int dones);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
  endtask

  initial begin
    int dc;
    bit bok;
    int dones;

    vecs[0]  = '{OP_MUL,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{OP_MUL,  1'b0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{OP_MUL,  1'b1, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[3]  = '{OP_MTHI, 1'b0, 32'h00000000, 32'h0,        32'h00000000, 32'hFFFFFFEB};
    vecs[4]  = '{OP_MTLO, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h00000000, 32'hFFFFFFFF};
    vecs[5]  = '{OP_MADD, 1'b0, 32'h00000002, 32'h00000003, 32'h00000001, 32'h00000005};
    vecs[6]  = '{OP_NOP,  1'b0, 32'hDEADBEEF, 32'h1,        32'h00000001, 32'h00000005};
    vecs[7]  = '{OP_DIV,  1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[8]  = '{OP_DIV,  1'b1, 32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
    vecs[9]  = '{OP_DIV,  1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[10] = '{OP_DIV,  1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[11] = '{OP_DIV,  1'b0, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[12] = '{OP_MUL,  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[13] = '{OP_MADD, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3FFFFFFE, 32'h00000001};
    vecs[14] = '{OP_MADD, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h3FFFFFFE, 32'h00000000};
    vecs[15] = '{OP_DIV,  1'b1, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[16] = '{OP_DIV,  1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[17] = '{OP_DIV,  1'b0, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2};

    reset_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_op = OP_NOP; bus.req_unsigned = 1'b0;
    bus.req_a = '0; bus.req_b = '0; bus.kill = 1'b0;
    repeat (2) @(negedge clock);
    check("reset hi", bus.hi, 32'h0);
    check("reset lo", bus.lo, 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.done), 32'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // back-to-back: each request is issued in the done cycle of the previous one
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].op inside {OP_MUL, OP_MADD, OP_DIV}) begin
        run_op(vecs[i].op, vecs[i].uns, vecs[i].a, vecs[i].b, dc, bok);
        check($sformatf("v%0d done_cycle", i), 32'(dc), 32'd35);
        check($sformatf("v%0d busy_window", i), 32'(bok), 32'd1);
      end else begin
        move_op(vecs[i].op, vecs[i].a);
        check($sformatf("v%0d busy", i), 32'(bus.busy), 32'h0);
        check($sformatf("v%0d done", i), 32'(bus.done), 32'h0);
      end
      check($sformatf("v%0d hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("v%0d lo", i), bus.lo, vecs[i].exp_lo);
    end

    // kill in N+10 of a DIV, then MTHI in N+11
    move_op(OP_MTHI, 32'hAAAA0000);
    move_op(OP_MTLO, 32'h00005555);
    dones = 0;
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_unsigned = 1'b1;
    bus.req_a = 32'd100; bus.req_b = 32'd7;
    @(negedge clock);
    bus.req_valid = 1'b0;
    step(9, dones);
    check("kill busy_before", 32'(bus.busy), 32'h1);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    check("kill busy_after", 32'(bus.busy), 32'h0);
    check("kill done", 32'(bus.done), 32'h0);
    check("kill hi", bus.hi, 32'hAAAA0000);
    check("kill lo", bus.lo, 32'h00005555);
    move_op(OP_MTHI, 32'h12345678);
    check("post_kill mthi hi", bus.hi, 32'h12345678);
    check("post_kill mthi lo", bus.lo, 32'h00005555);
    step(40, dones);
    check("kill no_done", 32'(dones), 32'd0);

    // kill during FIXUP (cycle N+34) suppresses the write
    bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_a = 32'd3; bus.req_b = 32'd5;
    @(negedge clock);
    bus.req_valid = 1'b0;
    step(33, dones);
    check("fixup_kill busy_before", 32'(bus.busy), 32'h1);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    check("fixup_kill busy_after", 32'(bus.busy), 32'h0);
    step(5, dones);
    check("fixup_kill no_done", 32'(dones), 32'd0);
    check("fixup_kill hi", bus.hi, 32'h12345678);
    check("fixup_kill lo", bus.lo, 32'h00005555);

    // kill with an idle request drops it, including moves and iterative ops
    bus.kill = 1'b1;
    move_op(OP_MTLO, 32'h0000BEEF);
    move_op(OP_DIV, 32'd9);
    bus.kill = 1'b0;
    check("idle_kill lo", bus.lo, 32'h00005555);
    check("idle_kill busy", 32'(bus.busy), 32'h0);

    // request presented while busy is ignored
    bus.req_valid = 1'b1; bus.req_op = OP_MUL; bus.req_unsigned = 1'b1;
    bus.req_a = 32'd3; bus.req_b = 32'd5;
    @(negedge clock);
    bus.req_valid = 1'b0;
    dones = 0;
    step(4, dones);
    move_op(OP_MTHI, 32'h0000DEAD);
    dc = -1;
    for (int k = 6; k <= 60; k++) begin
      if (bus.done) begin dc = k; break; end
      @(negedge clock);
    end
    check("busy_ignore done_cycle", 32'(dc), 32'd35);
    check("busy_ignore hi", bus.hi, 32'h0);
    check("busy_ignore lo", bus.lo, 32'h0000000F);

    // reset pulsed in N+5 of a DIV, then a cold DIV
    bus.req_valid = 1'b1; bus.req_op = OP_DIV; bus.req_unsigned = 1'b1;
    bus.req_a = 32'd100; bus.req_b = 32'd7;
    @(negedge clock);
    bus.req_valid = 1'b0;
    step(4, dones);
    reset_n = 1'b0;
    #1;
    check("midreset hi", bus.hi, 32'h0);
    check("midreset lo", bus.lo, 32'h0);
    check("midreset busy", 32'(bus.busy), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_op(OP_DIV, 1'b1, 32'd100, 32'd7, dc, bok);
    check("cold div done_cycle", 32'(dc), 32'd35);
    check("cold div busy_window", 32'(bok), 32'd1);
    check("cold div hi", bus.hi, 32'd2);
    check("cold div lo", bus.lo, 32'd14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
